instruction_issue: RTL
======================

// Module: instruction_issue
// PURPOSE
//  Consumer end of the ID->IX interface (id_valid/id_ix_inf). Buffers decoded instructions in a small in-order queue.
//  Tracks pending register writes in a 32-entry scoreboard and dispatches the queue head through a one-entry output slot.
//  Destination is one of the ALU/MUL/DIV/LSU pipes (valid/ready per pipe). Throttles fetch/decode via ix_stall_ifd.
// PARAMETERS
//  IQ_DEPTH     4   issue-queue entries; power of 2, >=4
//  STALL_SLACK  2   entries reserved for instructions already in flight in IFD/ID when the stall is raised
// PORTS
//  clk            in   1              clock
//  rst            in   1              async reset, active-high
//  wb_do_branch   in   1              flush (taken branch/jump resolved in WB)
//  id_valid       in   1              decoded instruction present
//  id_ix_inf      in   id_ix_inf_t    decoded fields (a1, a2, rd, register_write, exe_pipe, ...)
//  ix_stall_ifd   out  1              stall fetch/decode
//  ix_pipe_valid  out  4              one-hot, indexed by EXE_PIPE_ID_{ALU,MUL,DIV,LSU}
//  ix_pipe_ready  in   4              per-pipe accept
//  ix_inf         out  id_ix_inf_t    instruction held in the output slot
//  wb_clr_valid   in   4              per-pipe retirement of a register-writing instruction
//  wb_clr_rd      in   20             4x5b destination register; pipe k uses bits [5k+4:5k]
// BEHAVIOUR
//  Reset (async): queue count=0, rd/wr ptrs=0, pending=32'b0, ix_pipe_valid=0, ix_inf='0, ix_stall_ifd=0.
//  Queue: push when id_valid. Push and pop in the same cycle leave count unchanged.
//   id_valid while count==IQ_DEPTH is a protocol error: assertion fires and the entry is dropped.
//   Pointers wrap modulo IQ_DEPTH.
//  ix_stall_ifd = registered (count_next >= IQ_DEPTH-STALL_SLACK).
//  Hazard on head (all compares ignore x0):
//   RAW: pending[a1] | pending[a2].
//   WAW: register_write & pending[rd].
//  Slot free: ix_pipe_valid==0, or (ix_pipe_valid & ix_pipe_ready)!=0 this cycle.
//  Issue: head valid & !hazard & slot free -> pop the head, load ix_inf, ix_pipe_valid<=head.exe_pipe next cycle.
//   If register_write: pending[rd]<=1.
//  exe_pipe==0 (EXE_PIPE_INVALID, e.g. non-fence.i FENCE): popped when slot free; never presented; no scoreboard update.
//  Slot holds ix_inf/ix_pipe_valid stable until ready. It may reload in the same cycle it transfers (back-to-back issue).
//  Latency: id_valid at cycle N -> earliest ix_pipe_valid at N+2.
//  Scoreboard clear: for each k, wb_clr_valid[k] -> pending[wb_clr_rd[k]]<=0.
//   Several clears per cycle are allowed.
//   Set and clear of the same register in the same cycle: set wins.
//  Flush (wb_do_branch): next cycle queue empty, ix_pipe_valid=0, and a push in the same cycle is ignored.
//   Scoreboard is NOT cleared: every instruction that entered the slot reports wb_clr exactly once, even if squashed downstream.
//  Flush in the same cycle as a slot transfer: the transfer completes (pipe squashes it), then the slot is emptied.
// CONFIGURATION
//  SCOREBOARD_BYPASS_EN defined: the hazard check uses pending & ~clr_mask_this_cycle.
//   A consumer can issue in the same cycle its producer retires.
//  Not defined: the hazard check uses the registered pending only, adding a 1-cycle bubble per dependency.
//   Bench checks the cycle count for each mode.
// TESTING
//  1. Reset mid-stream with 3 queued entries and slot valid -> next cycle count=0, ix_pipe_valid=0, pending=0, ix_stall_ifd=0.
//  2. Back-to-back independent ADD x1 and ADD x2, ALU ready held 1 -> ix_pipe_valid=0001 at consecutive cycles N+2, N+3; pending=0x6.
//  3. MUL x5 then ADD x6,x5,x0; wb_clr_valid[MUL] with rd=5 at cycle T.
//     ADD presented at T+1 with SCOREBOARD_BYPASS_EN, at T+2 without.
//  4. ALU ready held 0, 6 pushes with IQ_DEPTH=4 -> ix_stall_ifd=1 once count reaches 2; no overflow assertion; order preserved on release.
//  5. Queue of 3 plus slot valid, wb_do_branch=1 with id_valid=1 -> next cycle empty, slot invalid, pending bits of issued rd still set.
//  6. FENCE (exe_pipe=0) between two LSU loads -> popped silently; loads presented on ix_pipe_valid=1000 in order; no stall created.

Source files
------------

// File: rtl/instruction_issue.sv
// -----------------------------------------------------------------------------
// instruction_issue
//
// Consumer end of the ID->IX interface. Decoded instructions are buffered in a
// small in-order queue. A 32-entry scoreboard tracks registers with a write in
// flight. The queue head is dispatched through a one-entry output slot to one
// of four execution pipes (ALU/MUL/DIV/LSU), each with its own valid/ready.
// Fetch/decode is throttled through a registered stall.
//
// Parameters
//   IQ_DEPTH     issue-queue entries (power of 2, >= 4)
//   STALL_SLACK  entries kept free for instructions already in IFD/ID when
//                the stall goes up
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous reset, active-high
//   wb_do_branch_i   flush: empties the queue and the output slot
//   id_valid_i       decoded instruction present on id_ix_inf_i
//   id_ix_inf_i      decoded instruction fields
//   ix_stall_ifd_o   stall fetch/decode
//   ix_pipe_valid_o  one-hot pipe select of the slot (0 = slot empty)
//   ix_pipe_ready_i  per-pipe accept
//   ix_inf_o         instruction held in the output slot
//   wb_clr_valid_i   per-pipe retirement of a register-writing instruction
//   wb_clr_rd_i      per-pipe retired rd, pipe k on bits [5k+4:5k]
//
// Configuration
//   SCOREBOARD_BYPASS_EN  when defined, registers retiring this cycle do not
//                         count as pending for the hazard check, so a consumer
//                         can issue in the same cycle as its producer retires.
// -----------------------------------------------------------------------------
package instruction_issue_pkg;

    localparam int unsigned EXE_PIPE_ID_ALU = 0;
    localparam int unsigned EXE_PIPE_ID_MUL = 1;
    localparam int unsigned EXE_PIPE_ID_DIV = 2;
    localparam int unsigned EXE_PIPE_ID_LSU = 3;

    localparam logic [3:0] EXE_PIPE_INVALID = 4'b0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic        register_write;
        logic [3:0]  exe_pipe;  // one-hot by EXE_PIPE_ID_*, 0 = no pipe (e.g. FENCE)
    } id_ix_inf_t;

endpackage

module instruction_issue
    import instruction_issue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH    = 4,
    parameter int unsigned STALL_SLACK = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_do_branch_i,
    input  logic        id_valid_i,
    input  id_ix_inf_t  id_ix_inf_i,
    output logic        ix_stall_ifd_o,
    output logic [3:0]  ix_pipe_valid_o,
    input  logic [3:0]  ix_pipe_ready_i,
    output id_ix_inf_t  ix_inf_o,
    input  logic [3:0]  wb_clr_valid_i,
    input  logic [19:0] wb_clr_rd_i
);

    localparam int unsigned PtrW = $clog2(IQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    id_ix_inf_t        iq_q [IQ_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       pending_q, pending_d;
    logic [3:0]        slot_valid_q, slot_valid_d;
    id_ix_inf_t        slot_inf_q, slot_inf_d;
    logic              stall_q, stall_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    id_ix_inf_t  head;
    logic        head_valid;
    logic        full;
    logic        push;
    logic        pop;
    logic        issue;
    logic        slot_free;
    logic        raw_hazard;
    logic        waw_hazard;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;
    logic [31:0] pend_chk;

    assign head       = iq_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign full       = (count_q == CntW'(IQ_DEPTH));

    // Decode all retirements of this cycle into one register mask.
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (wb_clr_valid_i[k]) begin
                clr_mask[wb_clr_rd_i[5*k +: 5]] = 1'b1;
            end
        end
    end

`ifdef SCOREBOARD_BYPASS_EN
    assign pend_chk = pending_q & ~clr_mask;
`else
    assign pend_chk = pending_q;
`endif

    // x0 is never a real dependency; the explicit compares keep that true even
    // if a stray clear/set ever touched bit 0.
    assign raw_hazard = ((head.a1 != 5'd0) && pend_chk[head.a1]) ||
                        ((head.a2 != 5'd0) && pend_chk[head.a2]);
    assign waw_hazard = head.register_write && (head.rd != 5'd0) && pend_chk[head.rd];

    // The slot can take a new instruction if it is empty or is being
    // accepted this very cycle (back-to-back issue).
    assign slot_free = (slot_valid_q == 4'b0000) ||
                       ((slot_valid_q & ix_pipe_ready_i) != 4'b0000);

    // Nothing is issued during a flush: the slot is emptied next cycle
    // anyway, and issuing would set scoreboard bits that nobody retires.
    assign issue = head_valid && !raw_hazard && !waw_hazard && slot_free && !wb_do_branch_i;
    assign pop   = issue;

    // A push into a full queue is a protocol error; the entry is dropped.
    assign push  = id_valid_i && !full && !wb_do_branch_i;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        slot_valid_d = slot_valid_q;
        slot_inf_d   = slot_inf_q;
        set_mask     = '0;

        if (wb_do_branch_i) begin
            // Any transfer happening this cycle still completes downstream;
            // the pipe squashes it. Only the slot/queue state is dropped.
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            slot_valid_d = 4'b0000;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);

            if (issue) begin
                // A pipe-less instruction is consumed here and never shown.
                slot_valid_d = head.exe_pipe;
                if (head.exe_pipe != EXE_PIPE_INVALID) begin
                    slot_inf_d = head;
                    if (head.register_write && (head.rd != 5'd0)) begin
                        set_mask[head.rd] = 1'b1;
                    end
                end
            end else if (slot_free) begin
                slot_valid_d = 4'b0000;
            end
        end

        // Set after clear: a new producer of a register that retires in the
        // same cycle keeps it pending.
        pending_d = (pending_q & ~clr_mask) | set_mask;

        stall_d = (32'(count_d) >= (IQ_DEPTH - STALL_SLACK));
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            slot_valid_q <= 4'b0000;
            slot_inf_q   <= '0;
            stall_q      <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            slot_valid_q <= slot_valid_d;
            slot_inf_q   <= slot_inf_d;
            stall_q      <= stall_d;
        end
    end

    // Queue storage carries no reset; entries are only read while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            iq_q[wr_ptr_q] <= id_ix_inf_i;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ix_pipe_valid_o = slot_valid_q;
    assign ix_inf_o        = slot_inf_q;
    assign ix_stall_ifd_o  = stall_q;

    // ---------------------------------------------------------------------
    // Protocol checks
    // ---------------------------------------------------------------------
`ifndef SYNTHESIS
    iq_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(id_valid_i && !wb_do_branch_i && full));

    slot_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ix_pipe_valid_o));
`endif

endmodule
